// File: rtl/sll_pkg.sv
// Shared types and helpers for the iterative shift-left unit.
package sll_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  function automatic logic [31:0] stage_amt(input logic [31:0] cnt);
    return 32'd1 << cnt;
  endfunction

endpackage

// File: rtl/sll_iter_if.sv
// Operand/result handshake bundle between the ALU control and the shift unit.
interface sll_iter_if
  import sll_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   movement;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             lost;
  logic             zero;

  modport master (
    output in_valid, a, movement, out_ready,
    input  in_ready, out_valid, out, lost, zero
  );

  modport slave (
    input  in_valid, a, movement, out_ready,
    output in_ready, out_valid, out, lost, zero
  );

endinterface

// File: rtl/sll_stage.sv
// One conditional shift-left stage by 2**cnt, also reporting whether any
// set bit falls off the MSB end.
module sll_stage
  import sll_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic [SHW-1:0]   i_cnt,
  output logic [WIDTH-1:0] o_data,
  output logic             o_lost
);

  logic [31:0]      w_amt;
  logic [WIDTH-1:0] w_keepMask;

  always_comb begin
    w_amt      = stage_amt(32'(i_cnt));
    // The top w_amt bits are the ones pushed out past the MSB.
    w_keepMask = {WIDTH{1'b1}} >> w_amt;
    o_data     = i_data;
    o_lost     = 1'b0;
    if (i_en) begin
      o_data = i_data << w_amt;
      o_lost = |(i_data & ~w_keepMask);
    end
  end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical shift-left: one binary stage per clock (16,8,4,2,1),
// fixed latency of SHW cycles regardless of shift amount.
module sll_iter
  import sll_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  sll_iter_if.slave bus
);

  localparam logic [SHW-1:0] CNT_TOP = SHW'(SHW - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_mv;
  logic [SHW-1:0]   r_cnt;
  logic             r_lost;
  logic [WIDTH-1:0] w_stageData;
  logic             w_stageLost;
  logic             w_accept;

  sll_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_stage (
    .i_data (r_data),
    .i_en   (r_mv[r_cnt]),
    .i_cnt  (r_cnt),
    .o_data (w_stageData),
    .o_lost (w_stageLost)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_accept = bus.in_valid;
        if (bus.in_valid) w_next = SHIFT;
      end
      SHIFT: if (r_cnt == '0) w_next = DONE;
      DONE:  if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Datapath registers: capture on accept, then walk the counter down one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_mv   <= '0;
      r_cnt  <= CNT_TOP;
      r_lost <= 1'b0;
    end else if (w_accept) begin
      r_data <= bus.a;
      r_mv   <= bus.movement;
      r_cnt  <= CNT_TOP;
      r_lost <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_data <= w_stageData;
      r_lost <= r_lost | w_stageLost;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out       = r_data;
  assign bus.lost      = r_lost;
  assign bus.zero      = (r_data == '0);

endmodule

// File: tb/tb_sll_iter.sv
// Scoreboard bench for sll_iter: randomized and directed shifts checked
// against a 64-bit arithmetic reference model.
module tb_sll_iter;

  typedef struct {
    logic [31:0] out;
    logic        lost;
    logic        zero;
    int          accCycle;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   readyMode;
  exp_t expQ[$];

  sll_iter_if #(.WIDTH(32), .SHW(5)) bus ();

  sll_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic exp_t refModel(input logic [31:0] a, input logic [4:0] mv, input int acc);
    exp_t        e;
    logic [63:0] wide;
    wide       = {32'b0, a} << mv;
    e.out      = wide[31:0];
    e.lost     = |wide[63:32];
    e.zero     = (wide[31:0] == 32'b0);
    e.accCycle = acc;
    return e;
  endfunction

  // out_ready driver: always high, held low, or random backpressure
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: latency on the rising out_valid, stability while held, pop on consume
  initial begin
    logic prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
      end else begin
        if (bus.out_valid) begin
          checkOutput("inReadyBusy", 32'(bus.in_ready), 32'd0);
          if (expQ.size() == 0) begin
            checkOutput("unexpectedValid", 32'(bus.out_valid), 32'd0);
          end else begin
            if (!prevValid)
              checkOutput("latency", 32'(cyc - expQ[0].accCycle), 32'd5);
            checkOutput("out",  bus.out,        expQ[0].out);
            checkOutput("lost", 32'(bus.lost), 32'(expQ[0].lost));
            checkOutput("zero", 32'(bus.zero), 32'(expQ[0].zero));
            if (bus.out_ready) void'(expQ.pop_front());
          end
        end
        prevValid = bus.out_valid && !bus.out_ready;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic applyStimulus(input logic [31:0] a, input logic [4:0] mv);
    logic willAccept;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.movement = mv;
    for (int i = 0; i < 200; i++) begin
      willAccept = bus.in_ready;
      @(posedge clk);
      #1;
      if (willAccept) begin
        expQ.push_back(refModel(a, mv, cyc));
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.movement = 5'($urandom);
        return;
      end
    end
    checkOutput("acceptTimeout", 32'd1, 32'd0);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0 && bus.in_ready) return;
      @(posedge clk);
      #1;
    end
    checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    readyMode    = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.movement = '0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("rstInReady",  32'(bus.in_ready),  32'd1);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstOut",      bus.out,            32'd0);
    checkOutput("rstLost",     32'(bus.lost),      32'd0);
    checkOutput("rstZero",     32'(bus.zero),      32'd1);
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    applyStimulus(32'h0000_0001, 5'd5);
    waitDrain();
    applyStimulus(32'h8000_0001, 5'd31);
    waitDrain();
    applyStimulus(32'hFFFF_FFFF, 5'd0);
    waitDrain();
    applyStimulus(32'h00FF_0000, 5'd16);
    waitDrain();

    // Backpressure with ignored in_valid pulses while busy
    readyMode = 1;
    @(posedge clk);
    #1;
    applyStimulus(32'h1234_5678, 5'd4);
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = $urandom_range(0, 1) != 0;
      bus.a        = $urandom;
      checkOutput("inReadyStall", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    readyMode = 0;
    waitDrain();

    // Asynchronous reset in the middle of SHIFT
    applyStimulus(32'h0000_00F1, 5'd3);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    expQ.delete();
    checkOutput("midRstInReady",  32'(bus.in_ready),  32'd1);
    checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstOut",      bus.out,            32'd0);
    checkOutput("midRstLost",     32'(bus.lost),      32'd0);
    checkOutput("midRstZero",     32'(bus.zero),      32'd1);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_0003, 5'd1);
    waitDrain();

    // Randomized operations under random backpressure
    readyMode = 2;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      logic [4:0]  rm;
      ra = $urandom;
      rm = 5'($urandom);
      if (n % 10 == 0) rm = 5'd31;
      if (n % 10 == 1) rm = 5'd0;
      if (n % 7 == 0)  ra = ra >> $urandom_range(0, 31);
      applyStimulus(ra, rm);
    end
    readyMode = 0;
    waitDrain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
